fetch_queue: RTL and testbench

//   2-wide in-order instruction buffer between instruction fetch and decode/rename.

---
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : 2-wide in-order instruction buffer between instruction fetch
//                and decode/rename. Each cycle it accepts 0-2 fetched
//                instructions and presents the 0-2 oldest entries. The output
//                is first-word fall-through and always packed low (00/01/11).
//                A flush empties the queue in one cycle.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   clock, rising edge
//    rst           in   synchronous active-high reset
//    flush         in   discard all entries (redirect)
//    fetch_valid   in   [1:0] per-slot valid from fetch (00/01/10/11)
//    fetch_addr_0  in   PC of fetch slot 0
//    fetch_inst_0  in   instruction of fetch slot 0
//    fetch_addr_1  in   PC of fetch slot 1
//    fetch_inst_1  in   instruction of fetch slot 1
//    fetch_ready   out  queue accepts a fetch group this cycle
//    rename_ready  in   rename consumes every valid output slot
//    dec_valid     out  [1:0] output valid (00/01/11)
//    dec_addr_0    out  PC of oldest entry
//    dec_inst_0    out  instruction of oldest entry
//    dec_addr_1    out  PC of second-oldest entry
//    dec_inst_1    out  instruction of second-oldest entry
//    count         out  current occupancy
// ============================================================================
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 fetch_valid,
  input  logic [ADDR_WIDTH-1:0]      fetch_addr_0,
  input  logic [DATA_WIDTH-1:0]      fetch_inst_0,
  input  logic [ADDR_WIDTH-1:0]      fetch_addr_1,
  input  logic [DATA_WIDTH-1:0]      fetch_inst_1,
  output logic                       fetch_ready,
  input  logic                       rename_ready,
  output logic [1:0]                 dec_valid,
  output logic [ADDR_WIDTH-1:0]      dec_addr_0,
  output logic [DATA_WIDTH-1:0]      dec_inst_0,
  output logic [ADDR_WIDTH-1:0]      dec_addr_1,
  output logic [DATA_WIDTH-1:0]      dec_inst_1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] c_READY_MAX = CW'(DEPTH - 2);
  localparam logic [PW-1:0] c_PTR_ONE   = PW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_inst [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                  w_fetch_ready;
  logic                  w_enq_fire;
  logic [1:0]            w_n_enq;
  logic [1:0]            w_n_deq;
  logic [1:0]            w_dec_valid;
  logic [PW-1:0]         w_head_p1;
  logic [PW-1:0]         w_tail_p1;
  logic [CW-1:0]         w_count_next;

  // First write port always lands at tail; second only for a full 11 group.
  logic                  w_wr0_en;
  logic [ADDR_WIDTH-1:0] w_wr0_addr;
  logic [DATA_WIDTH-1:0] w_wr0_inst;
  logic                  w_wr1_en;

  // Readiness looks only at current occupancy; guaranteeing room for two
  // entries regardless of same-cycle dequeue keeps this off the rename path.
  assign w_fetch_ready = (r_count <= c_READY_MAX);

  assign w_enq_fire = w_fetch_ready & (|fetch_valid) & ~flush;

  assign w_n_enq = w_enq_fire ? ({1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]})
                              : 2'd0;

  always_comb begin
    w_dec_valid = 2'b00;
    if (r_count == CW'(0)) begin
      w_dec_valid = 2'b00;
    end else if (r_count == CW'(1)) begin
      w_dec_valid = 2'b01;
    end else begin
      w_dec_valid = 2'b11;
    end
  end

  // Rename takes everything offered or nothing; an empty queue yields zero.
  assign w_n_deq = (rename_ready & ~flush)
                 ? ({1'b0, w_dec_valid[0]} + {1'b0, w_dec_valid[1]})
                 : 2'd0;

  assign w_head_p1 = r_head + c_PTR_ONE;
  assign w_tail_p1 = r_tail + c_PTR_ONE;

  assign w_count_next = r_count + {{(CW-2){1'b0}}, w_n_enq}
                                - {{(CW-2){1'b0}}, w_n_deq};

  // Slot 0 is older than slot 1; a lone slot-1 instruction (10) still packs
  // into the tail position so the queue stays contiguous.
  always_comb begin
    w_wr0_en   = w_enq_fire;
    w_wr0_addr = fetch_addr_0;
    w_wr0_inst = fetch_inst_0;
    w_wr1_en   = w_enq_fire & fetch_valid[0] & fetch_valid[1];
    if (!fetch_valid[0]) begin
      w_wr0_addr = fetch_addr_1;
      w_wr0_inst = fetch_inst_1;
    end
  end

  // --------------------------------------------------------------------------
  // Storage (contents need no reset; occupancy gates visibility)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr0_en) begin
      r_addr[r_tail] <= w_wr0_addr;
      r_inst[r_tail] <= w_wr0_inst;
    end
    if (w_wr1_en) begin
      r_addr[w_tail_p1] <= fetch_addr_1;
      r_inst[w_tail_p1] <= fetch_inst_1;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= w_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (first-word fall-through from head)
  // --------------------------------------------------------------------------
  assign fetch_ready = w_fetch_ready;
  assign dec_valid   = w_dec_valid;
  assign dec_addr_0  = r_addr[r_head];
  assign dec_inst_0  = r_inst[r_head];
  assign dec_addr_1  = r_addr[w_head_p1];
  assign dec_inst_1  = r_inst[w_head_p1];
  assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. Directed scenarios
//                followed by randomized traffic, all compared against a
//                queue-based reference model of the instruction buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    fetch_valid;
  logic [AW-1:0] fetch_addr_0;
  logic [DW-1:0] fetch_inst_0;
  logic [AW-1:0] fetch_addr_1;
  logic [DW-1:0] fetch_inst_1;
  logic          fetch_ready;
  logic          rename_ready;
  logic [1:0]    dec_valid;
  logic [AW-1:0] dec_addr_0;
  logic [DW-1:0] dec_inst_0;
  logic [AW-1:0] dec_addr_1;
  logic [DW-1:0] dec_inst_1;
  logic [CW-1:0] count;

  fetch_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_addr_0 (fetch_addr_0),
    .fetch_inst_0 (fetch_inst_0),
    .fetch_addr_1 (fetch_addr_1),
    .fetch_inst_1 (fetch_inst_1),
    .fetch_ready  (fetch_ready),
    .rename_ready (rename_ready),
    .dec_valid    (dec_valid),
    .dec_addr_0   (dec_addr_0),
    .dec_inst_0   (dec_inst_0),
    .dec_addr_1   (dec_addr_1),
    .dec_inst_1   (dec_inst_1),
    .count        (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: program-order list of {addr, inst}, oldest at [0].
  logic [AW+DW-1:0] r_mq [$];
  bit               r_known = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic set_fetch(input logic [1:0] fv, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    fetch_valid  = fv;
    fetch_addr_0 = a0;
    fetch_inst_0 = inst_of(a0);
    fetch_addr_1 = a1;
    fetch_inst_1 = inst_of(a1);
  endtask

  // Compare the current DUT view with the model, advance the model using the
  // inputs currently driven, then move past the next rising edge.
  task automatic cycle();
    int sz;
    int ndeq;
    bit rdy;
    sz = r_mq.size();
    if (r_known) begin
      chk("count", 64'(count), 64'(sz));
      chk("fetch_ready", 64'(fetch_ready), 64'(sz <= DEPTH - 2));
      chk("dec_valid", 64'(dec_valid), (sz == 0) ? 64'd0 : (sz == 1) ? 64'd1 : 64'd3);
      if (sz >= 1) begin
        chk("dec_addr_0", 64'(dec_addr_0), 64'(r_mq[0][AW+DW-1:DW]));
        chk("dec_inst_0", 64'(dec_inst_0), 64'(r_mq[0][DW-1:0]));
      end
      if (sz >= 2) begin
        chk("dec_addr_1", 64'(dec_addr_1), 64'(r_mq[1][AW+DW-1:DW]));
        chk("dec_inst_1", 64'(dec_inst_1), 64'(r_mq[1][DW-1:0]));
      end
    end
    if (rst) begin
      r_mq.delete();
      r_known = 1'b1;
    end else if (r_known) begin
      if (flush) begin
        r_mq.delete();
      end else begin
        rdy  = (sz <= DEPTH - 2);
        ndeq = rename_ready ? ((sz < 2) ? sz : 2) : 0;
        repeat (ndeq) void'(r_mq.pop_front());
        if (rdy) begin
          if (fetch_valid[0]) r_mq.push_back({fetch_addr_0, fetch_inst_0});
          if (fetch_valid[1]) r_mq.push_back({fetch_addr_1, fetch_inst_1});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_fetch(2'b00, '0, '0);
    flush        = 1'b0;
    rename_ready = 1'b1;
    repeat (DEPTH / 2 + 1) cycle();
    rename_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    rename_ready = 1'b0;
    set_fetch(2'b00, '0, '0);

    // 1. reset for two cycles, then idle
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // 2. one 11 group held, then consumed
    set_fetch(2'b11, 32'h0, 32'h4);
    cycle();
    set_fetch(2'b00, '0, '0);
    chk("t2_addr0", 64'(dec_addr_0), 64'h0);
    chk("t2_addr1", 64'(dec_addr_1), 64'h4);
    cycle();
    rename_ready = 1'b1;
    cycle();
    rename_ready = 1'b0;
    chk("t2_count_after", 64'(count), 64'd0);
    cycle();

    // 3. fill to full, fifth group ignored
    for (int i = 0; i < 4; i++) begin
      set_fetch(2'b11, 32'(8 * i), 32'(8 * i + 4));
      cycle();
    end
    set_fetch(2'b11, 32'h20, 32'h24);
    cycle();
    cycle();
    chk("t3_full_ready", 64'(fetch_ready), 64'd0);
    chk("t3_head", 64'(dec_addr_0), 64'h0);
    drain();

    // 4. lone slot 0, then lone slot 1
    set_fetch(2'b01, 32'h10, 32'hDEAD);
    cycle();
    set_fetch(2'b10, 32'hBEEF, 32'h18);
    cycle();
    set_fetch(2'b00, '0, '0);
    chk("t4_addr1", 64'(dec_addr_1), 64'h18);
    cycle();
    drain();

    // 5. streaming across pointer wrap
    rename_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_fetch(2'b11, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i));
      cycle();
    end
    drain();

    // 6. flush at count 5 with concurrent enqueue/dequeue
    set_fetch(2'b11, 32'h40, 32'h44);
    cycle();
    set_fetch(2'b11, 32'h48, 32'h4C);
    cycle();
    set_fetch(2'b01, 32'h50, 32'h0);
    cycle();
    flush        = 1'b1;
    rename_ready = 1'b1;
    set_fetch(2'b11, 32'h60, 32'h64);
    cycle();
    flush        = 1'b0;
    rename_ready = 1'b0;
    set_fetch(2'b11, 32'h200, 32'h204);
    cycle();
    set_fetch(2'b00, '0, '0);
    chk("t6_addr0", 64'(dec_addr_0), 64'h200);
    cycle();
    drain();

    // Randomized traffic, including occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      rename_ready = ($urandom_range(0, 2) != 0);
      fetch_valid  = 2'($urandom_range(0, 3));
      fetch_addr_0 = $urandom;
      fetch_inst_0 = $urandom;
      fetch_addr_1 = $urandom;
      fetch_inst_1 = $urandom;
      cycle();
    end
    rst   = 1'b0;
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
